y_addr_sequencer: RTL
=====================

Y_ADDR_SEQUENCER -- requirements
Module: y_addr_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 11, address width of requests, line reads and outputs.
REQ-002 Parameter: LINE_W, default 256, width of one Y-matrix SRAM line.
REQ-003 Parameter: ENTRY_W, default 16, width of one row-pointer entry in a line; LINE_W/ENTRY_W SHALL be a power of two; ENT_SH = log2(LINE_W/ENTRY_W).
REQ-004 Parameter: NUM_CH, default 2, range 2..8, number of output address channels.
REQ-005 Parameter: SRAM_LAT, default 1, range 1..4, cycles from line_rd_en sample to line_rd_data valid.
REQ-006 clock  input  1  clock; all logic on posedge.
REQ-007 reset  input  1  reset, synchronous, active-low.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts request.
REQ-010 req_row  input  ADDR_W  Y-matrix row index.
REQ-011 req_addr1  input  ADDR_W  explicit address 1 (zero = absent).
REQ-012 req_addr2  input  ADDR_W  explicit address 2 (zero = absent).
REQ-013 line_rd_en  output  1  SRAM line read strobe.
REQ-014 line_rd_addr  output  ADDR_W  SRAM line address.
REQ-015 line_rd_data  input  LINE_W  SRAM line data.
REQ-016 out_valid  output  1  output addresses valid.
REQ-017 out_ready  input  1  consumer accepts output.
REQ-018 out_addr  output  NUM_CH*ADDR_W  channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-019 out_err  output  1  illegal request, qualified by out_valid.
REQ-020 out_wrap  output  1  an address wrapped modulo 2^ADDR_W, qualified by out_valid.

Function
REQ-021 Mode SHALL be {|req_addr1, |req_addr2}, latched at acceptance: 00 FETCH, 10 BASE, 11 DIRECT, 01 ILLEGAL.
REQ-022 Acceptance: req_valid && req_ready at a rising edge; req_ready SHALL equal (state == IDLE).
REQ-023 States: IDLE, FETCH, WAIT, CALC, OUT.
REQ-024 IDLE: on acceptance, FETCH mode -> FETCH; all other modes -> OUT with results registered at the same edge.
REQ-025 FETCH: one cycle; line_rd_en = 1, line_rd_addr = req_row >> ENT_SH; then -> WAIT.
REQ-026 WAIT: SRAM_LAT cycles, counted by a down-counter; then -> CALC.
REQ-027 CALC: one cycle; line_rd_data captured; base = low ADDR_W bits of entry req_row[ENT_SH-1:0] (bits [idx*ENTRY_W +: ADDR_W]); then -> OUT.
REQ-028 Results: FETCH/BASE: channel k = base + k, where base = req_addr1 in BASE mode; DIRECT: ch0 = req_addr1, ch1 = req_addr2, ch k>=2 = req_addr2 + (k-1); ILLEGAL: all channels 0, out_err = 1.
REQ-029 All additions SHALL be ADDR_W-bit modulo 2^ADDR_W; out_wrap = 1 if any channel's true sum exceeds 2^ADDR_W - 1.
REQ-030 OUT: out_valid = 1 and out_addr/out_err/out_wrap held stable until out_valid && out_ready; then -> IDLE.
REQ-031 Latency from acceptance edge T: BASE/DIRECT/ILLEGAL out_valid in cycle T+1; FETCH line_rd_en in T+1, out_valid in T+3+SRAM_LAT.
REQ-032 line_rd_en SHALL be 0 outside FETCH; line_rd_data SHALL be ignored outside CALC.
REQ-033 A request is never dropped; back-to-back throughput is one request per two cycles at most (OUT then IDLE).

Reset
REQ-034 While reset == 0 at an edge: state = IDLE, counter = 0, out_valid = 0, out_addr = 0, out_err = 0, out_wrap = 0, line_rd_en = 0, line_rd_addr = 0.
REQ-035 Reset in any state SHALL abort the operation; late line_rd_data arriving after reset SHALL have no effect.

Structure
REQ-036 Package y_addr_pkg SHALL hold the mode and state enums and an ENT_SH helper function.
REQ-037 Combinational entry selection SHALL be sub-module y_entry_select (line, index -> ADDR_W base).

Verification
REQ-038 FETCH: row=0x023, entry 3 of line = 0x01F0 -> line_rd_addr=0x002 in T+1; out_addr ch0=0x1F0, ch1=0x1F1 in T+4 (SRAM_LAT=1).
REQ-039 BASE wrap: addr1=0x7FF, addr2=0 -> ch0=0x7FF, ch1=0x000, out_wrap=1 in T+1.
REQ-040 DIRECT: addr1=0x010, addr2=0x200, NUM_CH=4 -> 0x010, 0x200, 0x201, 0x202; out_wrap=0.
REQ-041 ILLEGAL: addr1=0, addr2=0x005 -> out_valid with out_err=1, all channels 0, no line_rd_en.
REQ-042 Backpressure: out_ready low 3 cycles -> out_addr stable, req_ready=0; accepts a new request the cycle after the handshake.
REQ-043 Reset asserted during WAIT -> IDLE next cycle, out_valid=0, subsequent line_rd_data ignored.

Source files
------------

// File: rtl/y_addr_pkg.sv
// rtl/y_addr_pkg.sv - shared enums and helpers for the Y-matrix address sequencer
package y_addr_pkg;

  typedef enum logic [1:0] {
    MODE_FETCH   = 2'b00,
    MODE_ILLEGAL = 2'b01,
    MODE_BASE    = 2'b10,
    MODE_DIRECT  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CALC,
    S_OUT
  } state_e;

  function automatic int ent_sh(input int line_w, input int entry_w);
    return $clog2(line_w / entry_w);
  endfunction

endpackage

// File: rtl/y_addr_sequencer_if.sv
// rtl/y_addr_sequencer_if.sv - request, SRAM line and output bundle of the address sequencer
interface y_addr_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int LINE_W = 256,
  parameter int NUM_CH = 2
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_W-1:0]        req_row;
  logic [ADDR_W-1:0]        req_addr1;
  logic [ADDR_W-1:0]        req_addr2;
  logic                     line_rd_en;
  logic [ADDR_W-1:0]        line_rd_addr;
  logic [LINE_W-1:0]        line_rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*ADDR_W-1:0] out_addr;
  logic                     out_err;
  logic                     out_wrap;

  // master is the environment: requester, SRAM and output consumer together
  modport master (
    output req_valid, req_row, req_addr1, req_addr2, line_rd_data, out_ready,
    input  req_ready, line_rd_en, line_rd_addr, out_valid, out_addr, out_err, out_wrap
  );

  modport slave (
    input  req_valid, req_row, req_addr1, req_addr2, line_rd_data, out_ready,
    output req_ready, line_rd_en, line_rd_addr, out_valid, out_addr, out_err, out_wrap
  );
endinterface

// File: rtl/y_entry_select.sv
// rtl/y_entry_select.sv - picks one row-pointer entry out of an SRAM line
module y_entry_select #(
  parameter int ADDR_W  = 11,
  parameter int LINE_W  = 256,
  parameter int ENTRY_W = 16,
  parameter int ENT_SH  = 4
) (
  input  logic [LINE_W-1:0] i_line,
  input  logic [ENT_SH-1:0] i_idx,
  output logic [ADDR_W-1:0] o_base
);
  assign o_base = i_line[i_idx*ENTRY_W +: ADDR_W];
endmodule

// File: rtl/y_addr_sequencer.sv
// rtl/y_addr_sequencer.sv - turns a row/explicit-address request into NUM_CH output addresses
module y_addr_sequencer
  import y_addr_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int LINE_W   = 256,
  parameter int ENTRY_W  = 16,
  parameter int NUM_CH   = 2,
  parameter int SRAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  y_addr_sequencer_if.slave bus
);
  localparam int ENT_SH = ent_sh(LINE_W, ENTRY_W);

  state_e                   r_state, w_next;
  mode_e                    r_mode, w_req_mode, w_mode;
  logic [ENT_SH-1:0]        r_idx;
  logic [2:0]               r_cnt;
  logic                     r_line_rd_en;
  logic [ADDR_W-1:0]        r_line_rd_addr;
  logic                     r_out_valid, r_out_err, r_out_wrap;
  logic [NUM_CH*ADDR_W-1:0] r_out_addr;

  logic                     w_accept;
  logic [ADDR_W-1:0]        w_entry_base, w_base;
  logic [NUM_CH*ADDR_W-1:0] w_res_addr;
  logic                     w_res_err, w_res_wrap;

  assign w_accept   = bus.req_valid && (r_state == S_IDLE);
  assign w_req_mode = mode_e'({|bus.req_addr1, |bus.req_addr2});

  y_entry_select #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .ENTRY_W(ENTRY_W),
    .ENT_SH (ENT_SH)
  ) u_entry_select (
    .i_line(bus.line_rd_data),
    .i_idx (r_idx),
    .o_base(w_entry_base)
  );

  // Results come straight from the request in IDLE and from the fetched line in CALC
  always_comb begin : p_results
    logic [ADDR_W:0] v_sum;
    v_sum      = '0;
    w_res_addr = '0;
    w_res_wrap = 1'b0;
    w_mode     = (r_state == S_IDLE) ? w_req_mode : r_mode;
    w_base     = (w_mode == MODE_FETCH) ? w_entry_base : bus.req_addr1;
    w_res_err  = (w_mode == MODE_ILLEGAL);
    for (int k = 0; k < NUM_CH; k++) begin
      case (w_mode)
        MODE_DIRECT:  v_sum = (k == 0) ? {1'b0, bus.req_addr1}
                                       : {1'b0, bus.req_addr2} + (ADDR_W+1)'(k - 1);
        MODE_ILLEGAL: v_sum = '0;
        default:      v_sum = {1'b0, w_base} + (ADDR_W+1)'(k);
      endcase
      w_res_addr[k*ADDR_W +: ADDR_W] = v_sum[ADDR_W-1:0];
      w_res_wrap = w_res_wrap | v_sum[ADDR_W];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_req_mode == MODE_FETCH) ? S_FETCH : S_OUT;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_next = S_CALC;
      S_CALC:  w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_mode         <= MODE_FETCH;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_line_rd_en   <= 1'b0;
      r_line_rd_addr <= '0;
      r_out_valid    <= 1'b0;
      r_out_addr     <= '0;
      r_out_err      <= 1'b0;
      r_out_wrap     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_line_rd_en <= (w_next == S_FETCH);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode <= w_req_mode;
            r_idx  <= bus.req_row[ENT_SH-1:0];
            if (w_req_mode == MODE_FETCH) begin
              r_line_rd_addr <= bus.req_row >> ENT_SH;
            end else begin
              r_out_valid <= 1'b1;
              r_out_addr  <= w_res_addr;
              r_out_err   <= w_res_err;
              r_out_wrap  <= w_res_wrap;
            end
          end
        end
        S_FETCH: r_cnt <= 3'(SRAM_LAT - 1);
        S_WAIT:  if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        S_CALC: begin
          r_out_valid <= 1'b1;
          r_out_addr  <= w_res_addr;
          r_out_err   <= w_res_err;
          r_out_wrap  <= w_res_wrap;
        end
        S_OUT:   if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.line_rd_en   = r_line_rd_en;
  assign bus.line_rd_addr = r_line_rd_addr;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_addr     = r_out_addr;
  assign bus.out_err      = r_out_err;
  assign bus.out_wrap     = r_out_wrap;
endmodule
